// File: rtl/apb_wrr_arbiter.sv
// apb_wrr_arbiter: weighted round-robin grant controller for a shared APB slave port.
// Optional forced release of a stalled ACCESS phase is enabled by defining APB_ARB_TIMEOUT_EN.
module apb_wrr_arbiter #(
    parameter int NUM_APB_MASTERS = 9,
    parameter int WEIGHT_WIDTH    = 4,
    parameter int TIMEOUT_CYCLES  = 64,
    localparam int IW = $clog2(NUM_APB_MASTERS)
) (
    input  logic                                    PCLK,
    input  logic                                    PRESET,
    input  logic [NUM_APB_MASTERS-1:0]              req_i,
    input  logic [NUM_APB_MASTERS*WEIGHT_WIDTH-1:0] weight_i,
    input  logic                                    PSEL_m,
    input  logic                                    PENABLE_m,
    input  logic                                    PREADY_m,
    output logic [NUM_APB_MASTERS-1:0]              grant_o,
    output logic [IW-1:0]                           grant_idx_o,
    output logic                                    busy_o,
    output logic                                    timeout_o
);
    localparam int N  = NUM_APB_MASTERS;
    localparam int WW = WEIGHT_WIDTH;
    localparam logic [IW:0] NL = (IW+1)'(N);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t          r_state;
    logic [N-1:0]    r_grant;
    logic [IW-1:0]   r_idx;
    logic [IW-1:0]   r_ptr;
    logic [WW-1:0]   r_credit;
    logic            r_busy;
    logic [N-1:0]    w_rot;
    logic [IW-1:0]   w_off;
    logic [IW:0]     w_sum;
    logic [IW-1:0]   w_win;
    logic            w_found;
    logic [IW-1:0]   w_nxt;
    logic [WW-1:0]   w_win_wt;
    logic [WW-1:0]   w_nxt_wt;

    // a zero weight still earns one transfer per turn
    function automatic logic [WW-1:0] ld(input logic [WW-1:0] w);
        return (w == '0) ? WW'(1) : w;
    endfunction

    // circular first-requester search starting at the rotation pointer
    always_comb begin
        w_rot   = N'({req_i, req_i} >> r_ptr);
        w_found = |req_i;
        w_off   = '0;
        for (int i = N-1; i >= 0; i--)
            if (w_rot[i]) w_off = IW'(i);
        w_sum    = {1'b0, r_ptr} + {1'b0, w_off};
        w_win    = (w_sum >= NL) ? IW'(w_sum - NL) : w_sum[IW-1:0];
        w_nxt    = (r_idx == IW'(N-1)) ? '0 : r_idx + 1'b1;
        w_win_wt = WW'(weight_i >> (w_win * WW));
        w_nxt_wt = WW'(weight_i >> (w_nxt * WW));
    end

`ifdef APB_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] r_tcnt;
    logic          r_timeout;
    assign timeout_o = r_timeout;
`else
    assign timeout_o = 1'b0;
`endif

    // transfer FSM: grant is latched in IDLE and held until completion, abandon or forced release
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_state  <= IDLE;
            r_grant  <= '0;
            r_idx    <= '0;
            r_busy   <= 1'b0;
            r_ptr    <= '0;
            r_credit <= ld(weight_i[WW-1:0]);
`ifdef APB_ARB_TIMEOUT_EN
            r_tcnt    <= '0;
            r_timeout <= 1'b0;
`endif
        end else begin
`ifdef APB_ARB_TIMEOUT_EN
            r_timeout <= 1'b0;
`endif
            case (r_state)
                IDLE: if (w_found) begin
                    r_state <= SETUP;
                    r_grant <= N'(1) << w_win;
                    r_idx   <= w_win;
                    r_busy  <= 1'b1;
                    if (w_win != r_ptr) begin
                        r_ptr    <= w_win;
                        r_credit <= ld(w_win_wt);
                    end
                end
                SETUP: if (PSEL_m && PENABLE_m) begin
                    r_state <= ACCESS;
`ifdef APB_ARB_TIMEOUT_EN
                    r_tcnt  <= '0;
`endif
                end else if (!req_i[r_idx]) begin
                    r_state <= IDLE;
                    r_grant <= '0;
                    r_busy  <= 1'b0;
                end
                ACCESS: if (PSEL_m && PENABLE_m && PREADY_m) begin
                    r_state <= IDLE;
                    r_grant <= '0;
                    r_busy  <= 1'b0;
                    if (r_credit <= WW'(1)) begin
                        r_ptr    <= w_nxt;
                        r_credit <= ld(w_nxt_wt);
                    end else begin
                        r_credit <= r_credit - 1'b1;
                    end
                end
`ifdef APB_ARB_TIMEOUT_EN
                else if (r_tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    r_state   <= IDLE;
                    r_grant   <= '0;
                    r_busy    <= 1'b0;
                    r_timeout <= 1'b1;
                    r_ptr     <= w_nxt;
                    r_credit  <= ld(w_nxt_wt);
                end else begin
                    r_tcnt <= r_tcnt + 1'b1;
                end
`endif
                default: r_state <= IDLE;
            endcase
        end
    end

    assign grant_o     = r_grant;
    assign grant_idx_o = r_idx;
    assign busy_o      = r_busy;
endmodule

// File: tb/tb_apb_wrr_arbiter.sv
// tb_apb_wrr_arbiter: directed vector bench for apb_wrr_arbiter (9 masters, 4-bit weights).
module tb_apb_wrr_arbiter;
    logic        PCLK = 1'b0;
    logic        PRESET = 1'b1;
    logic [8:0]  req_i = '0;
    logic [35:0] weight_i = 36'h111111111;
    logic        PSEL_m = 1'b0;
    logic        PENABLE_m = 1'b0;
    logic        PREADY_m = 1'b0;
    logic [8:0]  grant_o;
    logic [3:0]  grant_idx_o;
    logic        busy_o;
    logic        timeout_o;
    int          errs = 0;
    int          checks = 0;

    apb_wrr_arbiter #(.NUM_APB_MASTERS(9), .WEIGHT_WIDTH(4), .TIMEOUT_CYCLES(8)) dut (
        .PCLK(PCLK), .PRESET(PRESET), .req_i(req_i), .weight_i(weight_i),
        .PSEL_m(PSEL_m), .PENABLE_m(PENABLE_m), .PREADY_m(PREADY_m),
        .grant_o(grant_o), .grant_idx_o(grant_idx_o), .busy_o(busy_o), .timeout_o(timeout_o)
    );

    always #5 PCLK = ~PCLK;

    typedef struct packed {
        logic [8:0]      req;
        logic [35:0]     wts;
        logic [0:5][3:0] seq;
    } vec_t;

    vec_t vecs [5];

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset(input logic [35:0] w);
        PRESET = 1'b1;
        weight_i = w;
        req_i = '0;
        PSEL_m = 1'b0;
        PENABLE_m = 1'b0;
        PREADY_m = 1'b0;
        tick();
        PRESET = 1'b0;
        tick();
    endtask

    // one full transfer for the master expected to hold the grant right now
    task automatic xfer(input logic [3:0] e);
        logic [8:0] oh;
        oh = 9'b1 << e;
        chk("grant", {23'd0, grant_o}, {23'd0, oh});
        chk("grant_idx", {28'd0, grant_idx_o}, {28'd0, e});
        chk("busy", {31'd0, busy_o}, 32'd1);
        PSEL_m = 1'b1; PENABLE_m = 1'b0; PREADY_m = 1'b1;
        tick();
        chk("setup_hold", {23'd0, grant_o}, {23'd0, oh});
        PENABLE_m = 1'b1; PREADY_m = 1'b0;
        tick();
        tick();
        chk("access_hold", {23'd0, grant_o}, {23'd0, oh});
        PREADY_m = 1'b1;
        tick();
        chk("release", {23'd0, grant_o}, 32'd0);
        chk("idle_busy", {31'd0, busy_o}, 32'd0);
        chk("idx_hold", {28'd0, grant_idx_o}, {28'd0, e});
        PSEL_m = 1'b0; PENABLE_m = 1'b0; PREADY_m = 1'b1;
        tick();
        PREADY_m = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{9'h007, 36'h111111111, {4'd0, 4'd1, 4'd2, 4'd0, 4'd1, 4'd2}};
        vecs[1] = '{9'h090, 36'h111131111, {4'd4, 4'd4, 4'd4, 4'd7, 4'd4, 4'd4}};
        vecs[2] = '{9'h101, 36'h011111111, {4'd0, 4'd8, 4'd0, 4'd8, 4'd0, 4'd8}};
        vecs[3] = '{9'h003, 36'h111111102, {4'd0, 4'd0, 4'd1, 4'd0, 4'd0, 4'd1}};
        vecs[4] = '{9'h020, 36'h111111111, {4'd5, 4'd5, 4'd5, 4'd5, 4'd5, 4'd5}};

        tick();
        chk("rst_grant", {23'd0, grant_o}, 32'd0);
        chk("rst_idx", {28'd0, grant_idx_o}, 32'd0);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_timeout", {31'd0, timeout_o}, 32'd0);

        for (int v = 0; v < 5; v++) begin
            do_reset(vecs[v].wts);
            req_i = vecs[v].req;
            tick();
            for (int n = 0; n < 6; n++) xfer(vecs[v].seq[n]);
            req_i = '0;
            tick();
        end

        // abandon in SETUP consumes no credit: weight 2 master wins twice afterwards
        do_reset(36'h111111211);
        req_i = 9'h004;
        tick();
        chk("abandon_pre", {23'd0, grant_o}, 32'h004);
        req_i = '0;
        tick();
        chk("abandon_grant", {23'd0, grant_o}, 32'd0);
        chk("abandon_busy", {31'd0, busy_o}, 32'd0);
        req_i = 9'h00c;
        tick();
        xfer(4'd2);
        xfer(4'd2);
        xfer(4'd3);
        req_i = '0;
        tick();

        // asynchronous reset during ACCESS drops the grant and returns ptr to 0
        do_reset(36'h111111111);
        req_i = 9'h020;
        tick();
        chk("rst_mid_grant_pre", {23'd0, grant_o}, 32'h020);
        PSEL_m = 1'b1; PENABLE_m = 1'b0;
        tick();
        PENABLE_m = 1'b1;
        tick();
        chk("rst_mid_busy_pre", {31'd0, busy_o}, 32'd1);
        PRESET = 1'b1;
        #1;
        chk("rst_mid_grant", {23'd0, grant_o}, 32'd0);
        chk("rst_mid_busy", {31'd0, busy_o}, 32'd0);
        tick();
        PRESET = 1'b0;
        PSEL_m = 1'b0; PENABLE_m = 1'b0;
        req_i = 9'h048;
        tick();
        chk("rst_mid_ptr", {28'd0, grant_idx_o}, 32'd3);
        req_i = '0;
        tick();

        // stalled ACCESS phase with PREADY held low
        do_reset(36'h111111111);
        req_i = 9'h060;
        tick();
        chk("stall_grant_pre", {23'd0, grant_o}, 32'h020);
        PSEL_m = 1'b1; PENABLE_m = 1'b0;
        tick();
        PENABLE_m = 1'b1;
        tick();
`ifdef APB_ARB_TIMEOUT_EN
        repeat (7) tick();
        chk("to_hold_grant", {23'd0, grant_o}, 32'h020);
        chk("to_hold_pulse", {31'd0, timeout_o}, 32'd0);
        tick();
        chk("to_release", {23'd0, grant_o}, 32'd0);
        chk("to_pulse", {31'd0, timeout_o}, 32'd1);
        PSEL_m = 1'b0; PENABLE_m = 1'b0;
        tick();
        chk("to_pulse_end", {31'd0, timeout_o}, 32'd0);
        chk("to_next_grant", {23'd0, grant_o}, 32'h040);
`else
        repeat (100) tick();
        chk("stall_grant", {23'd0, grant_o}, 32'h020);
        chk("stall_busy", {31'd0, busy_o}, 32'd1);
        chk("stall_timeout", {31'd0, timeout_o}, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/apb_wrr_arbiter.md
Name: apb_wrr_arbiter

Overview:
Weighted round-robin grant controller for the shared APB slave port in the N-master-to-1-slave APB mux. It watches master requests and the muxed slave-side handshake, and issues a one-hot grant that steers the mux datapath. The grant is held for exactly one complete APB transfer (SETUP + ACCESS until PREADY). Each master receives a programmable number of consecutive transfers (weight) before priority rotates.

Parameters:
NUM_APB_MASTERS, 9, number of requesting masters (2..16)
WEIGHT_WIDTH, 4, bits per master weight field
TIMEOUT_CYCLES, 64, max ACCESS-phase cycles before forced release (only with APB_ARB_TIMEOUT_EN)

Ports:
PCLK  input  1  clock
PRESET  input  1  reset; asynchronous, active-high
req_i  input  NUM_APB_MASTERS  per-master request (each master's PSEL)
weight_i  input  NUM_APB_MASTERS*WEIGHT_WIDTH  packed weights; field k = master k; sampled at credit reload
PSEL_m  input  1  muxed PSEL toward the slave
PENABLE_m  input  1  muxed PENABLE toward the slave
PREADY_m  input  1  slave PREADY
grant_o  output  NUM_APB_MASTERS  one-hot grant to the mux; all-zero when idle
grant_idx_o  output  $clog2(NUM_APB_MASTERS)  binary index of the granted master; holds last value when idle
busy_o  output  1  high in SETUP or ACCESS
timeout_o  output  1  one-cycle pulse on forced release (tied 0 without the macro)

Behaviour:
- Reset (async, PRESET=1): state=IDLE; grant_o=0, grant_idx_o=0, busy_o=0, timeout_o=0; rotation pointer ptr=0; credit=max(weight_i[0],1).
- FSM IDLE/SETUP/ACCESS, all registered outputs.
- IDLE: if |req_i, winner = first k with req_i[k]=1, searching circularly from ptr. Next cycle: grant_o=onehot(winner), grant_idx_o=winner, state=SETUP. Latency is request-to-grant = 1 cycle.
- Winner != ptr (ptr master not requesting): ptr=winner, credit=max(weight[winner],1) before that transfer counts.
- Weight 0 is treated as 1.
- SETUP: if PSEL_m && PENABLE_m, go to ACCESS. If req_i[grant_idx] falls first, abandon: go to IDLE, grant cleared, no credit consumed, ptr unchanged.
- ACCESS: stay until PREADY_m=1 with PSEL_m && PENABLE_m. That cycle is completion: state=IDLE, grant_o=0 next cycle (one dead cycle between transfers).
- Credit on completion: credit-1. If the result is 0, ptr=(grant_idx+1) mod N and credit reloads from the new ptr's weight. Otherwise ptr stays, so the same master wins the next arbitration if still requesting.
- ptr wraps from N-1 to 0.
- grant_o never changes during SETUP/ACCESS, whatever req_i does. A new req from a higher-priority master waits.
- Simultaneous requests in IDLE: only the circular-first one wins; the others stay pending with no loss.
- PREADY_m while in IDLE or SETUP is ignored.
- Reset mid-transfer: grant drops immediately (async), FSM returns to IDLE, ptr=0.

Optional Feature:
APB_ARB_TIMEOUT_EN
- Defined: a counter clears on entry to ACCESS and increments each ACCESS cycle without PREADY_m. At count == TIMEOUT_CYCLES-1, force IDLE, clear the grant, pulse timeout_o for 1 cycle, and rotate ptr to grant_idx+1 with credit reload (offender loses remaining credit).
- Undefined: no counter; ACCESS waits indefinitely; timeout_o=0.

Test Plan:
- Reset, single request, weights all 1: req_i[0] set at cycle 0 → grant_o=9'h001 at cycle 1, busy_o=1. Slave PREADY in 2nd ACCESS cycle → grant_o=0 the following cycle; ptr=1.
- Weights 1, req_i[0],[1],[2] held simultaneously: grants in order 0,1,2,0; each grant held for exactly one transfer; one idle cycle between grants.
- Weight[4]=3, weight[7]=1, req 4 and 7 held continuously: grant sequence 4,4,4,7,4,4,4,7.
- ptr=8, req_i[8] and req_i[0] both high: grant 8, then 0 (wrap-around); weight[8]=0 gives exactly one transfer.
- Granted master 2 drops req in SETUP before PENABLE_m: grant_o=0 next cycle, and master 2 wins again on re-request (no credit consumed). Assert PRESET during ACCESS → grant_o=0 in the same cycle, ptr=0.
- With APB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, PREADY_m held 0: timeout_o pulses after the 8th ACCESS cycle, grant released, next pending master granted. Without the macro, the grant is still held at cycle 100.
